split_eval_sched: RTL



---
 rtl/split_eval_sched_if.sv | 37 +++
 rtl/split_eval_sched.sv | 90 +++++++++
 2 files changed

// File: rtl/split_eval_sched_if.sv
// split_eval_sched_if: candidate, checker-bank and result handshakes of split_eval_sched.
// master is the sequencer's view; slave is the surrounding logic's view.
interface split_eval_sched_if #(
    parameter int NUM_SPLITS = 16,
    parameter int CAND_W     = 512,
    parameter int ID_W       = 8,
    parameter int IDX_W      = $clog2(NUM_SPLITS)
);
    logic              cand_valid;
    logic              cand_ready;
    logic [CAND_W-1:0] cand_data;
    logic [ID_W-1:0]   cand_id;
    logic [CAND_W-1:0] split_vars;
    logic [IDX_W-1:0]  split_sel;
    logic              split_req;
    logic              split_ack;
    logic              split_x;
    logic              res_valid;
    logic              res_ready;
    logic              res_pass;
    logic [IDX_W-1:0]  res_fail_idx;
    logic [ID_W-1:0]   res_id;
    logic [15:0]       stat_pass;
    logic [15:0]       stat_fail;

    modport master (
        input  cand_valid, cand_data, cand_id, split_ack, split_x, res_ready,
        output cand_ready, split_vars, split_sel, split_req, res_valid, res_pass,
               res_fail_idx, res_id, stat_pass, stat_fail
    );

    modport slave (
        output cand_valid, cand_data, cand_id, split_ack, split_x, res_ready,
        input  cand_ready, split_vars, split_sel, split_req, res_valid, res_pass,
               res_fail_idx, res_id, stat_pass, stat_fail
    );
endinterface

// File: rtl/split_eval_sched.sv
// split_eval_sched: steps one candidate through all split checkers and reports pass/first-fail.
// Define SPLIT_EARLY_EXIT_EN to stop evaluating at the first failing split.
module split_eval_sched #(
    parameter int NUM_SPLITS = 16,
    parameter int CAND_W     = 512,
    parameter int ID_W       = 8,
    localparam int IDX_W     = $clog2(NUM_SPLITS)
) (
    input logic clk,
    input logic rst,
    split_eval_sched_if.master bus
);
    typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

    state_t           state, state_nx;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] fail_idx;
    logic [ID_W-1:0]  id;
    logic             pass;
    logic             fail_seen;
    logic             ack;
    logic             last;
    logic             stop;

    assign ack  = state == EVAL && bus.split_ack;
    assign last = idx == IDX_W'(NUM_SPLITS - 1);
`ifdef SPLIT_EARLY_EXIT_EN
    assign stop = last || !bus.split_x;
`else
    assign stop = last;
`endif

    assign bus.cand_ready   = state == IDLE;
    assign bus.split_req    = state == EVAL;
    assign bus.res_valid    = state == DONE;
    assign bus.split_sel    = idx;
    assign bus.res_pass     = pass;
    assign bus.res_fail_idx = fail_idx;
    assign bus.res_id       = id;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = bus.cand_valid ? EVAL : IDLE;
            EVAL:    state_nx = (bus.split_ack && stop) ? DONE : EVAL;
            DONE:    state_nx = bus.res_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            idx            <= '0;
            fail_idx       <= '0;
            id             <= '0;
            pass           <= 1'b0;
            fail_seen      <= 1'b0;
            bus.split_vars <= '0;
            bus.stat_pass  <= '0;
            bus.stat_fail  <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && bus.cand_valid) begin
                bus.split_vars <= bus.cand_data;
                id             <= bus.cand_id;
                idx            <= '0;
                fail_idx       <= '0;
                pass           <= 1'b1;
                fail_seen      <= 1'b0;
            end
            if (ack) begin
                // only the first failure is recorded, later ones keep the lowest index
                if (!bus.split_x && !fail_seen) begin
                    fail_idx  <= idx;
                    pass      <= 1'b0;
                    fail_seen <= 1'b1;
                end
                if (!stop)
                    idx <= idx + 1'b1;
            end
            if (state == DONE && bus.res_ready) begin
                if (pass && bus.stat_pass != 16'hFFFF)
                    bus.stat_pass <= bus.stat_pass + 16'd1;
                if (!pass && bus.stat_fail != 16'hFFFF)
                    bus.stat_fail <= bus.stat_fail + 16'd1;
            end
        end
    end
endmodule
